branch_ctrl_seq: RTL and testbench
==================================

Name: branch_ctrl_seq

Overview:
Hard-wired control sequencer for the fetch phase plus conditional-branch execution (brzr/brnz/brpl/brmi) of the datapath CPU. It sits directly upstream of the datapath and produces the per-T-state strobes (PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin, Gra, Rout, CONin, Yin, Cout, ADD, Zlowin) that the branch bench currently drives by hand. It also holds the CON flip-flop, which evaluates the branch condition from the bus and decides whether T6 loads PC.

Parameters:
OPC_BR, 5'b10010, IR[31:27] value identifying a branch instruction.
MEM_TIMEOUT, 8, number of cycles to wait for mem_ready in T1 before flagging a fault.

Ports:
clock  in  1  system clock, rising-edge.
clear  in  1  synchronous active-high reset.
run  in  1  start one fetch+execute sequence; sampled in IDLE only.
mem_ready  in  1  memory read data valid; completes the T1 wait.
ir  in  32  IR register contents (valid from T3 onward).
bus  in  32  datapath bus; carries R[Ra] during T3.
pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, read, mdr_in, mdr_out, ir_in, gra, r_out, con_in, y_in, c_out, add_op, zlow_in  out  1 each  datapath control strobes.
con_flag  out  1  CON FF state (branch taken).
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse on the final cycle of a sequence.
fault  out  1  sticky error flag: illegal opcode or memory timeout; cleared only by clear.

Behaviour:
- clear: state=IDLE; every strobe, con_flag, done and fault is 0; timeout counter is 0.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT. Strobes are Moore outputs, fully decoded from state. Exactly one T-state is active per cycle.
- IDLE: if run=1, go to T0; otherwise stay.
- T0: pc_out, mar_in, inc_pc, z_in. Go to T1.
- T1: zlow_out, pc_in, read, mdr_in.
  - Strobes are held while mem_ready=0; zlow_out/pc_in assert only in the first T1 cycle.
  - Advance to T2 on the cycle mem_ready=1.
  - If the counter reaches MEM_TIMEOUT, set fault and go to HALT.
- T2: mdr_out, ir_in. Go to T3.
- T3: first decode ir[31:27].
  - If it is not OPC_BR: set fault and go to HALT; no strobes issue.
  - Otherwise assert gra, r_out, con_in.
  - CON FF loads on this edge using C2=ir[20:19] against bus: 00 bus==0, 01 bus!=0, 10 bus[31]==0, 11 bus[31]==1.
- T4: pc_out, y_in.
- T5: c_out, add_op, zlow_in.
- T6: zlow_out always; pc_in=con_flag; done=1. Go to IDLE.
- HALT: all strobes 0, busy=1, done=0. Exit only via clear.
- con_flag holds its value between sequences; it updates only in T3.
- A run pulse that arrives while busy is ignored; no queueing.
- clear in any state, including mid-T1 wait, returns to IDLE on that edge with outputs zeroed.
- Fetch latency from run to done: 7 cycles plus the number of T1 wait cycles.

Optional Feature:
BRANCH_STATS_EN:
- Defined: adds outputs taken_cnt[15:0] and not_taken_cnt[15:0].
  - The matching counter increments in T6.
  - Both counters saturate at 16'hFFFF and reset to 0 on clear.
- Undefined: neither port nor counter exists.

Decomposition:
- Shared package: state encoding enum, the OPC_BR constant, and the C2 condition codes (BRZR=0, BRNZ=1, BRPL=2, BRMI=3).
- Sub-module con_ff: ir[20:19], bus, con_in, clock, clear -> con_flag. It contains the combinational condition decode plus the flag register.

Test Plan:
1. brmi taken: mem_ready tied 1, ir=32'h91180023, bus=32'hFFFFFFF0 in T3. Expect T0..T6 on consecutive cycles, con_flag=1, pc_in high in T6, done at cycle 7.
2. brzr not taken: ir=32'h91000023, bus=32'h00000005. Expect con_flag=0, pc_in low in T6, zlow_out high in T6.
3. Memory wait: mem_ready held low for 3 cycles in T1. Expect read/mdr_in high for 4 cycles, pc_in in the first T1 cycle only, done at cycle 10.
4. Timeout: mem_ready never asserted. Expect fault=1 after 8 T1 cycles, then HALT with all strobes 0 and busy=1.
5. Illegal opcode: ir=32'h08000000. Expect fault set in T3, no gra/con_in, state HALT; then clear returns IDLE with fault=0.
6. clear asserted mid-T4. Expect IDLE next edge, all outputs 0; a run issued while busy earlier produced no second sequence.

Source files
------------

// File: rtl/branch_ctrl_seq_pkg.sv
// branch_ctrl_seq_pkg
// Shared definitions for the fetch + conditional-branch control sequencer:
// state encoding, the branch opcode and the C2 condition codes.
package branch_ctrl_seq_pkg;

  // IR[31:27] value that identifies a branch instruction
  localparam logic [4:0] OPC_BR = 5'b10010;

  // C2 field (IR[20:19]) condition codes
  localparam logic [1:0] C2_BRZR = 2'd0;
  localparam logic [1:0] C2_BRNZ = 2'd1;
  localparam logic [1:0] C2_BRPL = 2'd2;
  localparam logic [1:0] C2_BRMI = 2'd3;

  // State encoding
  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_HALT = 4'd8;

  typedef enum logic [3:0] {
    ST_IDLE = S_IDLE,
    ST_T0   = S_T0,
    ST_T1   = S_T1,
    ST_T2   = S_T2,
    ST_T3   = S_T3,
    ST_T4   = S_T4,
    ST_T5   = S_T5,
    ST_T6   = S_T6,
    ST_HALT = S_HALT
  } state_e;

endpackage

// File: rtl/branch_ctrl_seq_con_ff.sv
// branch_ctrl_seq_con_ff
// CON flip-flop: decodes the branch condition from the bus and latches it
// when con_in is high.
// Ports:
//   clock    in   system clock, rising edge
//   clear    in   synchronous active-high reset
//   c2       in   condition field IR[20:19]
//   bus      in   datapath bus (R[Ra] while con_in is high)
//   con_in   in   load strobe
//   con_flag out  latched condition (branch taken)
module branch_ctrl_seq_con_ff
  import branch_ctrl_seq_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic [1:0]  c2,
  input  logic [31:0] bus,
  input  logic        con_in,
  output logic        con_flag
);

  logic cond;

  always_comb begin
    cond = 1'b0;
    case (c2)
      C2_BRZR: cond = (bus == 32'd0);
      C2_BRNZ: cond = (bus != 32'd0);
      C2_BRPL: cond = ~bus[31];
      C2_BRMI: cond = bus[31];
      default: cond = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear)       con_flag <= 1'b0;
    else if (con_in) con_flag <= cond;
  end

endmodule

// File: rtl/branch_ctrl_seq.sv
// branch_ctrl_seq
// Hard-wired control sequencer for instruction fetch plus conditional branch
// execution (brzr/brnz/brpl/brmi). Produces Moore-decoded datapath strobes.
// Optional feature macro: BRANCH_STATS_EN adds taken/not-taken counters.
// Ports:
//   clock, clear          clock and synchronous active-high reset
//   run                   start one fetch+execute sequence (IDLE only)
//   mem_ready             memory read data valid, ends the T1 wait
//   ir, bus               IR contents and datapath bus
//   pc_out .. zlow_in     datapath control strobes
//   con_flag              CON flip-flop (branch taken)
//   busy, done, fault     status; fault is sticky until clear
//   taken_cnt, not_taken_cnt   branch statistics (BRANCH_STATS_EN only)
//
// state | meaning
// IDLE  | waiting for run
// T0    | PC -> MAR, PC+1 -> Z
// T1    | Z -> PC (first cycle only), memory read, wait for mem_ready
// T2    | MDR -> IR
// T3    | decode; R[Ra] -> bus, CON FF loads
// T4    | PC -> Y
// T5    | Y + C -> Z
// T6    | Z -> PC if CON, done
// HALT  | fault trap, left only by clear
module branch_ctrl_seq
  import branch_ctrl_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 8
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  input  logic [31:0] bus,
  output logic        pc_out,
  output logic        mar_in,
  output logic        inc_pc,
  output logic        z_in,
  output logic        zlow_out,
  output logic        pc_in,
  output logic        read,
  output logic        mdr_in,
  output logic        mdr_out,
  output logic        ir_in,
  output logic        gra,
  output logic        r_out,
  output logic        con_in,
  output logic        y_in,
  output logic        c_out,
  output logic        add_op,
  output logic        zlow_in,
  output logic        con_flag,
  output logic        busy,
  output logic        done,
  output logic        fault
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0] taken_cnt,
  output logic [15:0] not_taken_cnt
`endif
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  // Down-counter is loaded in T0; terminal count 0 marks the last T1 cycle.
  localparam logic [TW-1:0] WAIT_LOAD = TW'(MEM_TIMEOUT - 1);

  logic [3:0]    state, state_nxt;
  logic [TW-1:0] wait_cnt;
  logic          op_ok, first_t1, t1_expire;
  logic          ir_unused;

  assign ir_unused = ^{ir[26:21], ir[18:0]};
  assign op_ok     = (ir[31:27] == OPC_BR);
  // The counter still holds its load value only in the first T1 cycle.
  assign first_t1  = (wait_cnt == WAIT_LOAD);
  assign t1_expire = (state == S_T1) && !mem_ready && (wait_cnt == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (run) state_nxt = S_T0;
      S_T0:   state_nxt = S_T1;
      S_T1:   if (mem_ready) state_nxt = S_T2;
              else if (wait_cnt == '0) state_nxt = S_HALT;
      S_T2:   state_nxt = S_T3;
      S_T3:   state_nxt = op_ok ? S_T4 : S_HALT;
      S_T4:   state_nxt = S_T5;
      S_T5:   state_nxt = S_T6;
      S_T6:   state_nxt = S_IDLE;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      fault    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_T0)
        wait_cnt <= WAIT_LOAD;
      else if (state == S_T1 && !mem_ready && wait_cnt != '0)
        wait_cnt <= wait_cnt - 1'b1;
      if (t1_expire || (state == S_T3 && !op_ok))
        fault <= 1'b1;
    end
  end

  // Moore strobes; T3 strobes are suppressed for a non-branch opcode.
  assign pc_out   = (state == S_T0) || (state == S_T4);
  assign mar_in   = (state == S_T0);
  assign inc_pc   = (state == S_T0);
  assign z_in     = (state == S_T0);
  assign zlow_out = (state == S_T1 && first_t1) || (state == S_T6);
  assign pc_in    = (state == S_T1 && first_t1) || (state == S_T6 && con_flag);
  assign read     = (state == S_T1);
  assign mdr_in   = (state == S_T1);
  assign mdr_out  = (state == S_T2);
  assign ir_in    = (state == S_T2);
  assign gra      = (state == S_T3) && op_ok;
  assign r_out    = (state == S_T3) && op_ok;
  assign con_in   = (state == S_T3) && op_ok;
  assign y_in     = (state == S_T4);
  assign c_out    = (state == S_T5);
  assign add_op   = (state == S_T5);
  assign zlow_in  = (state == S_T5);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_T6);

  branch_ctrl_seq_con_ff u_con_ff (
    .clock    (clock),
    .clear    (clear),
    .c2       (ir[20:19]),
    .bus      (bus),
    .con_in   (con_in),
    .con_flag (con_flag)
  );

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clock) begin
    if (clear) begin
      taken_cnt     <= 16'd0;
      not_taken_cnt <= 16'd0;
    end else if (state == S_T6) begin
      if (con_flag && taken_cnt != 16'hFFFF)
        taken_cnt <= taken_cnt + 16'd1;
      else if (!con_flag && not_taken_cnt != 16'hFFFF)
        not_taken_cnt <= not_taken_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_ctrl_seq.sv
// tb_branch_ctrl_seq
// Directed bench for branch_ctrl_seq. Each sequence pushes its expected
// per-cycle output vector to a scoreboard queue; the vectors are popped and
// compared on the falling edge as the DUT steps through its states.
module tb_branch_ctrl_seq;

  logic        clock = 1'b0;
  logic        clear, run, mem_ready;
  logic [31:0] ir, bus;
  logic pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, read, mdr_in, mdr_out;
  logic ir_in, gra, r_out, con_in, y_in, c_out, add_op, zlow_in;
  logic con_flag, busy, done, fault;
`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt, not_taken_cnt;
`endif

  always #5 clock = ~clock;

  branch_ctrl_seq dut (
    .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready),
    .ir(ir), .bus(bus),
    .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .z_in(z_in),
    .zlow_out(zlow_out), .pc_in(pc_in), .read(read), .mdr_in(mdr_in),
    .mdr_out(mdr_out), .ir_in(ir_in), .gra(gra), .r_out(r_out),
    .con_in(con_in), .y_in(y_in), .c_out(c_out), .add_op(add_op),
    .zlow_in(zlow_in), .con_flag(con_flag), .busy(busy), .done(done),
    .fault(fault)
`ifdef BRANCH_STATS_EN
    , .taken_cnt(taken_cnt), .not_taken_cnt(not_taken_cnt)
`endif
  );

  // Strobe order: pc_out mar_in inc_pc z_in zlow_out pc_in read mdr_in
  //               mdr_out ir_in gra r_out con_in y_in c_out add_op zlow_in
  localparam logic [16:0] V_Z   = 17'b00000000000000000;
  localparam logic [16:0] V_T0  = 17'b11110000000000000;
  localparam logic [16:0] V_T1F = 17'b00001111000000000;
  localparam logic [16:0] V_T1W = 17'b00000011000000000;
  localparam logic [16:0] V_T2  = 17'b00000000110000000;
  localparam logic [16:0] V_T3  = 17'b00000000001110000;
  localparam logic [16:0] V_T4  = 17'b10000000000001000;
  localparam logic [16:0] V_T5  = 17'b00000000000000111;
  localparam logic [16:0] V_T6N = 17'b00001000000000000;
  localparam logic [16:0] V_T6T = 17'b00001100000000000;

  int errors = 0;
  int checks = 0;
  logic [20:0] q[$];
  logic exp_con, exp_fault;
  int   exp_taken, exp_nt;
  bit   stop_b;
  int   clear_idx;

  logic [20:0] obs;
  assign obs = {pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, read, mdr_in,
                mdr_out, ir_in, gra, r_out, con_in, y_in, c_out, add_op,
                zlow_in, con_flag, busy, done, fault};

  function automatic logic cond_of(input logic [1:0] c2, input logic [31:0] b);
    case (c2)
      2'd0:    return (b == 32'd0);
      2'd1:    return (b != 32'd0);
      2'd2:    return !b[31];
      default: return b[31];
    endcase
  endfunction

  // Push one expected cycle; a clear scheduled on this cycle is followed by
  // an all-zero IDLE cycle and ends the sequence.
  task automatic add(input logic [16:0] s, input logic b, input logic d);
    if (!stop_b) begin
      q.push_back({s, exp_con, b, d, exp_fault});
      if (q.size() - 1 == clear_idx) begin
        exp_con = 1'b0; exp_fault = 1'b0; exp_taken = 0; exp_nt = 0;
        q.push_back({V_Z, 4'b0000});
        stop_b = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input int idx);
    logic [20:0] e;
    @(negedge clock);
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s cyc%0d observed=%b expected=<scoreboard empty>", tag, idx, obs);
    end else begin
      e = q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s cyc%0d observed=%b expected=%b", tag, idx, obs, e);
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic seq(input string tag, input logic [31:0] ir_v, input logic [31:0] bus_v,
                     input int waits, input int run2_at, input int clear_at);
    int n;
    stop_b = 1'b0;
    clear_idx = clear_at;
    add(V_Z, 1'b0, 1'b0);
    add(V_T0, 1'b1, 1'b0);
    add(V_T1F, 1'b1, 1'b0);
    n = (waits < 7) ? waits : 7;
    repeat (n) add(V_T1W, 1'b1, 1'b0);
    if (waits >= 8) begin
      exp_fault = 1'b1;
      repeat (3) add(V_Z, 1'b1, 1'b0);
    end else begin
      add(V_T2, 1'b1, 1'b0);
      if (ir_v[31:27] != 5'b10010) begin
        add(V_Z, 1'b1, 1'b0);
        exp_fault = 1'b1;
        repeat (3) add(V_Z, 1'b1, 1'b0);
      end else begin
        add(V_T3, 1'b1, 1'b0);
        if (!stop_b) exp_con = cond_of(ir_v[20:19], bus_v);
        add(V_T4, 1'b1, 1'b0);
        add(V_T5, 1'b1, 1'b0);
        add(exp_con ? V_T6T : V_T6N, 1'b1, 1'b1);
        if (!stop_b) begin
          if (exp_con) exp_taken++;
          else exp_nt++;
        end
        add(V_Z, 1'b0, 1'b0);
      end
    end
    for (int i = 0; q.size() > 0 && i < 300; i++) begin
      run       = (i == 0) || (i == run2_at);
      mem_ready = (i >= 2 + waits);
      clear     = (i == clear_at);
      ir        = ir_v;
      bus       = bus_v;
      chk(tag, i);
    end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s observed=%0d entries left expected=0", tag, q.size());
      q.delete();
    end
    run = 1'b0; clear = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic do_clear(input string tag);
    clear = 1'b1; run = 1'b0;
    @(posedge clock); #1;
    clear = 1'b0;
    exp_con = 1'b0; exp_fault = 1'b0; exp_taken = 0; exp_nt = 0;
    q.push_back({V_Z, 4'b0000});
    chk(tag, 0);
  endtask

  initial begin
    clear = 1'b1; run = 1'b0; mem_ready = 1'b0; ir = '0; bus = '0;
    exp_con = 1'b0; exp_fault = 1'b0; exp_taken = 0; exp_nt = 0;
    stop_b = 1'b0; clear_idx = -1;
    repeat (2) @(posedge clock);
    #1;
    q.push_back({V_Z, 4'b0000});
    chk("reset", 0);

    seq("brmi_taken",     32'h91180023, 32'hFFFFFFF0, 0,   -1, -1);
    seq("brzr_not_taken", 32'h91000023, 32'h00000005, 0,    4, -1);
    seq("brnz_wait3",     32'h91080023, 32'h00000005, 3,   -1, -1);
    seq("timeout",        32'h91080023, 32'h00000005, 100, -1, -1);
    do_clear("timeout_clear");
    seq("illegal_op",     32'h08000000, 32'h00000000, 0,   -1, -1);
    do_clear("illegal_clear");
    seq("clear_mid_t4",   32'h91100023, 32'h7FFFFFFF, 0,    3,  5);
    seq("brzr_wait7",     32'h91000023, 32'h00000000, 7,   -1, -1);

`ifdef BRANCH_STATS_EN
    checks++;
    assert (taken_cnt === 16'(exp_taken) && not_taken_cnt === 16'(exp_nt)) else begin
      errors++;
      $error("FAIL stats observed=%0d/%0d expected=%0d/%0d",
             taken_cnt, not_taken_cnt, exp_taken, exp_nt);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
